capture_trigger: RTL

//  Writer side of the sample RAM read by the VGA display. Streams 12-bit ADC samples into a

---
 rtl/capture_trigger.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/capture_trigger.sv
// Writer side of the sample RAM: streams ADC samples into a circular buffer, detects a
// level-crossing trigger and publishes the display start address once the record is complete.
module capture_trigger #(
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned DATA_W       = 12,
   parameter int unsigned PRE_SAMPLES  = 320,
   parameter int unsigned POST_SAMPLES = 5120,
   parameter int unsigned HYST         = 16,
   parameter int unsigned AUTO_TIMEOUT = 500000,
   parameter int unsigned HOLD_CYCLES  = 840000
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic              adc_valid,
   input  logic [DATA_W-1:0] adc_data,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_slope,
   input  logic              auto_mode,
   input  logic              run,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] mean_addr,
   output logic              mean_addr_found,
   output logic              forced
);

   localparam int unsigned MaxA   = (PRE_SAMPLES > POST_SAMPLES) ? PRE_SAMPLES : POST_SAMPLES;
   localparam int unsigned MaxB   = (HOLD_CYCLES > AUTO_TIMEOUT) ? HOLD_CYCLES : AUTO_TIMEOUT;
   localparam int unsigned CntMax = (MaxA > MaxB) ? MaxA : MaxB;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   localparam logic [CntW-1:0]   PreLast  = CntW'(PRE_SAMPLES - 1);
   localparam logic [CntW-1:0]   PostLast = CntW'(POST_SAMPLES - 1);
   localparam logic [CntW-1:0]   HoldLast = CntW'(HOLD_CYCLES - 1);
   localparam logic [CntW-1:0]   AutoLast = CntW'(AUTO_TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] PreOff   = ADDR_W'(PRE_SAMPLES);
   localparam logic [DATA_W:0]   HystW    = (DATA_W + 1)'(HYST);

   if (64'(PRE_SAMPLES) + 64'(POST_SAMPLES) + 64'd1 > (64'd1 << ADDR_W)) begin : g_depth_check
      $error("capture_trigger: PRE_SAMPLES + POST_SAMPLES + 1 exceeds buffer depth");
   end

   typedef enum logic [2:0] {StIdle, StFill, StArmed, StPost, StHold} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0]   level_q, level_d;
   logic                slope_q, slope_d;
   logic                arm_ok_q, arm_ok_d;
   logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
   logic [ADDR_W-1:0]   mean_addr_q, mean_addr_d;
   logic                forced_q, forced_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;

   logic [DATA_W:0]     hi_sum;
   logic [DATA_W-1:0]   lo_thr, hi_thr;
   logic                arm_cond, real_trig, timeout;

   // Hysteresis thresholds saturate at the ends of the sample range instead of wrapping.
   always_comb begin
      hi_sum = {1'b0, level_q} + HystW;
      hi_thr = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];
      lo_thr = ({1'b0, level_q} >= HystW) ? (level_q - HystW[DATA_W-1:0]) : '0;
      if (slope_q) begin
         arm_cond  = (adc_data > hi_thr);
         real_trig = arm_ok_q && (adc_data <= level_q);
      end else begin
         arm_cond  = (adc_data < lo_thr);
         real_trig = arm_ok_q && (adc_data >= level_q);
      end
      timeout = auto_mode && (cnt_q == AutoLast);
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      level_d     = level_q;
      slope_d     = slope_q;
      arm_ok_d    = arm_ok_q;
      trig_addr_d = trig_addr_q;
      mean_addr_d = mean_addr_q;
      forced_d    = forced_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;

      if (adc_valid && (state_q inside {StFill, StArmed, StPost})) begin
         wr_en_d   = 1'b1;
         wr_addr_d = ptr_q;
         wr_data_d = adc_data;
         ptr_d     = ptr_q + ADDR_W'(1);
      end

      unique case (state_q)
         StIdle: begin
            state_d = StFill;
            cnt_d   = '0;
         end
         StFill: begin
            if (adc_valid) begin
               if (cnt_q == PreLast) begin
                  state_d  = StArmed;
                  cnt_d    = '0;
                  level_d  = trig_level;
                  slope_d  = trig_slope;
                  arm_ok_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StArmed: begin
            // cnt_q is the auto-trigger timer here; it saturates so a late auto_mode fires at once.
            if (adc_valid) begin
               if (real_trig || timeout) begin
                  state_d     = StPost;
                  cnt_d       = '0;
                  trig_addr_d = ptr_q;
                  forced_d    = !real_trig;
               end else begin
                  if (arm_cond) arm_ok_d = 1'b1;
                  if (cnt_q != AutoLast) cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StPost: begin
            if (adc_valid) begin
               if (cnt_q == PostLast) begin
                  state_d     = StHold;
                  cnt_d       = '0;
                  mean_addr_d = trig_addr_q - PreOff;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StHold: begin
            if (cnt_q == HoldLast) begin
               if (run) begin
                  state_d = StFill;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         cnt_q       <= '0;
         level_q     <= '0;
         slope_q     <= 1'b0;
         arm_ok_q    <= 1'b0;
         trig_addr_q <= '0;
         mean_addr_q <= '0;
         forced_q    <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         slope_q     <= slope_d;
         arm_ok_q    <= arm_ok_d;
         trig_addr_q <= trig_addr_d;
         mean_addr_q <= mean_addr_d;
         forced_q    <= forced_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign wr_en           = wr_en_q;
   assign wr_addr         = wr_addr_q;
   assign wr_data         = wr_data_q;
   assign mean_addr       = mean_addr_q;
   assign mean_addr_found = (state_q == StHold);
   assign forced          = forced_q;

endmodule
